// File: rtl/int_stack_seq.sv
// Interrupt/RTI sequencer: injects push/pop micro-ops into the EX/MEM register
// and loads the interrupt vector; all outputs are registered from the next state.
module int_stack_seq #(
  parameter int unsigned     PC_W = 32,
  parameter logic [PC_W-1:0] VEC1 = '0,
  parameter logic [PC_W-1:0] VEC2 = PC_W'(32'h2)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            int_req,
  input  logic            int_num,
  input  logic            rti,
  input  logic            mem_busy,
  input  logic [PC_W-1:0] pc_in,
  output logic            stall_fetch,
  output logic            flush_dec,
  output logic            push_pc,
  output logic            push_ccr,
  output logic            pop_pc,
  output logic            pop_ccr,
  output logic            pc_half,
  output logic [15:0]     save_pc,
  output logic            int1_o,
  output logic            int2_o,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_vec,
  output logic            busy
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FLUSH    = 4'd1;
  localparam logic [3:0] S_PUSH_HI  = 4'd2;
  localparam logic [3:0] S_PUSH_LO  = 4'd3;
  localparam logic [3:0] S_PUSH_CCR = 4'd4;
  localparam logic [3:0] S_LOAD_VEC = 4'd5;
  localparam logic [3:0] S_POP_CCR  = 4'd6;
  localparam logic [3:0] S_POP_LO   = 4'd7;
  localparam logic [3:0] S_POP_HI   = 4'd8;
  localparam logic [3:0] S_RESUME   = 4'd9;

  logic [3:0]      r_state;
  logic            r_pend;
  logic            r_pend_num;
  logic            r_num;
  logic [PC_W-1:0] r_pc;

  logic [3:0]      w_next_state;
  logic            w_take;
  logic            w_want;
  logic            w_next_num;
  logic [PC_W-1:0] w_next_pc;
  logic            w_int_st;

  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    w_want       = int_req | r_pend;
    case (r_state)
      S_IDLE: begin
        if (rti) w_next_state = S_POP_CCR;
        else     w_take       = w_want;
      end
      S_FLUSH:    w_next_state = S_PUSH_HI;
      S_PUSH_HI:  if (!mem_busy) w_next_state = S_PUSH_LO;
      S_PUSH_LO:  if (!mem_busy) w_next_state = S_PUSH_CCR;
      S_PUSH_CCR: if (!mem_busy) w_next_state = S_LOAD_VEC;
      S_POP_CCR:  if (!mem_busy) w_next_state = S_POP_LO;
      S_POP_LO:   if (!mem_busy) w_next_state = S_POP_HI;
      S_POP_HI:   if (!mem_busy) w_next_state = S_RESUME;
      // Leaving the sequence counts as IDLE for acceptance, so a pending
      // interrupt starts without an idle gap cycle.
      S_LOAD_VEC, S_RESUME: begin
        w_next_state = S_IDLE;
        w_take       = w_want;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_take) w_next_state = S_FLUSH;
    w_next_num = w_take ? (int_req ? int_num : r_pend_num) : r_num;
    w_next_pc  = w_take ? pc_in : r_pc;
    w_int_st   = (w_next_state >= S_FLUSH) && (w_next_state <= S_LOAD_VEC);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pend      <= 1'b0;
      r_pend_num  <= 1'b0;
      r_num       <= 1'b0;
      r_pc        <= '0;
      stall_fetch <= 1'b0;
      flush_dec   <= 1'b0;
      push_pc     <= 1'b0;
      push_ccr    <= 1'b0;
      pop_pc      <= 1'b0;
      pop_ccr     <= 1'b0;
      pc_half     <= 1'b0;
      save_pc     <= '0;
      int1_o      <= 1'b0;
      int2_o      <= 1'b0;
      pc_load     <= 1'b0;
      pc_vec      <= '0;
      busy        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_num   <= w_next_num;
      r_pc    <= w_next_pc;
      if (w_take) begin
        r_pend <= 1'b0;
      end else if (int_req) begin
        r_pend     <= 1'b1;
        r_pend_num <= int_num;
      end
      stall_fetch <= (w_next_state != S_IDLE);
      busy        <= (w_next_state != S_IDLE);
      flush_dec   <= (w_next_state == S_FLUSH);
      push_pc     <= (w_next_state == S_PUSH_HI) || (w_next_state == S_PUSH_LO);
      push_ccr    <= (w_next_state == S_PUSH_CCR);
      pop_pc      <= (w_next_state == S_POP_LO) || (w_next_state == S_POP_HI);
      pop_ccr     <= (w_next_state == S_POP_CCR);
      pc_half     <= (w_next_state == S_PUSH_HI) || (w_next_state == S_POP_HI);
      if (w_next_state == S_PUSH_HI)      save_pc <= w_next_pc[31:16];
      else if (w_next_state == S_PUSH_LO) save_pc <= w_next_pc[15:0];
      else                                save_pc <= '0;
      int1_o  <= w_int_st && !w_next_num;
      int2_o  <= w_int_st && w_next_num;
      pc_load <= (w_next_state == S_LOAD_VEC);
      if (w_next_state == S_LOAD_VEC) pc_vec <= w_next_num ? VEC2 : VEC1;
      else                            pc_vec <= '0;
    end
  end

endmodule
